// File: rtl/video_stream_mon_if.sv
// AXI4-Stream video link (tuser = start of frame, tlast = end of line).
// Ports:
//   tdata  - pixel payload, DATAW bits
//   tvalid - beat valid, driven by the source
//   tready - beat accepted when high together with tvalid, driven by the sink
//   tuser  - start-of-frame marker on the first pixel of a frame
//   tlast  - end-of-line marker on the last pixel of a line
// Modports: master drives a stream out, slave receives a stream.
interface video_stream_mon_if #(
    parameter int unsigned DATAW = 32
);
    logic [DATAW-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tuser;
    logic             tlast;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/video_stream_mon.sv
// Video stream monitor: forwards an AXI4-Stream video stream through a
// 2-entry register slice and measures frame geometry on the accepted input
// beats.
// Ports:
//   clk, rst       - clock and asynchronous active-high reset
//   en             - monitor enable; the data path always runs
//   exp_w, exp_h   - expected active width/height, 0 selects EXPW/EXPH
//   clr_err        - one-cycle pulse clearing the sticky error flags
//   s_axis         - input stream (slave)
//   m_axis         - output stream (master)
//   meas_w, meas_h - width of the last line, line count of the last frame
//   frame_cnt      - completed frames, wrapping
//   err_*          - sticky protocol errors
//   locked         - last frame matched the expected geometry without errors
module video_stream_mon #(
    parameter int unsigned DATAW = 32,
    parameter int unsigned EXPW  = 1280,
    parameter int unsigned EXPH  = 720,
    parameter int unsigned FCNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [12:0]          exp_w,
    input  logic [12:0]          exp_h,
    input  logic                 clr_err,
    video_stream_mon_if.slave    s_axis,
    video_stream_mon_if.master   m_axis,
    output logic [12:0]          meas_w,
    output logic [12:0]          meas_h,
    output logic [FCNTW-1:0]     frame_cnt,
    output logic                 err_sof_early,
    output logic                 err_eol_early,
    output logic                 err_eol_late,
    output logic                 locked
);
    localparam int unsigned BeatW = DATAW + 2;
    localparam logic [12:0] XMax  = 13'h1fff;

    // ------------------------------------------------------------------
    // 2-entry buffer: {tdata, tuser, tlast} stored per entry
    // ------------------------------------------------------------------
    logic [BeatW-1:0] buf_q [2];
    logic [BeatW-1:0] buf_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             s_ready_q, s_ready_d;
    logic             push, pop;

    assign push = s_axis.tvalid & s_ready_q;
    assign pop  = (occ_q != 2'd0) & m_axis.tready;

    always_comb begin
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            buf_d[wr_ptr_q] = {s_axis.tdata, s_axis.tuser, s_axis.tlast};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // push is only possible below 2 entries, so occ_d never exceeds 2
        occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
        s_ready_d = (occ_d != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
            s_ready_q <= 1'b0;
        end else begin
            buf_q[0]  <= buf_d[0];
            buf_q[1]  <= buf_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = (occ_q != 2'd0);
    assign {m_axis.tdata, m_axis.tuser, m_axis.tlast} = buf_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Geometry monitor
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {StWaitSof, StActive} state_e;

    state_e           state_q, state_d;
    logic [12:0]      x_q, x_d;
    logic [12:0]      y_q, y_d;
    logic [12:0]      exp_w_q, exp_w_d;
    logic [12:0]      exp_h_q, exp_h_d;
    logic [12:0]      meas_w_q, meas_w_d;
    logic [12:0]      meas_h_q, meas_h_d;
    logic [FCNTW-1:0] frame_cnt_q, frame_cnt_d;
    logic             err_sof_q, err_sof_d;
    logic             err_early_q, err_early_d;
    logic             err_late_q, err_late_d;
    logic             locked_q, locked_d;
    logic             frm_err_q, frm_err_d;

    logic        proc;
    logic [12:0] eff_w, eff_h, cur_w, cur_h;
    logic [12:0] base_x, base_y, x_inc, y_inc;
    logic        new_sof_err, new_early_err, new_late_err, frame_done, frm_err_base;

    assign eff_w = (exp_w == 13'd0) ? 13'(EXPW) : exp_w;
    assign eff_h = (exp_h == 13'd0) ? 13'(EXPH) : exp_h;

    // A beat is processed in ACTIVE, or when it carries SOF (frame entry/restart)
    assign proc = en & push & ((state_q == StActive) | s_axis.tuser);

    // An SOF beat is handled as the first beat of a fresh frame
    assign cur_w        = s_axis.tuser ? eff_w : exp_w_q;
    assign cur_h        = s_axis.tuser ? eff_h : exp_h_q;
    assign base_x       = s_axis.tuser ? 13'd0 : x_q;
    assign base_y       = s_axis.tuser ? 13'd0 : y_q;
    assign frm_err_base = s_axis.tuser ? 1'b0 : frm_err_q;
    assign x_inc        = (base_x == XMax) ? XMax : base_x + 13'd1;
    assign y_inc        = base_y + 13'd1;

    assign new_sof_err   = proc & s_axis.tuser & (state_q == StActive) &
                           ((x_q != 13'd0) | (y_q != 13'd0));
    assign new_late_err  = proc & ~s_axis.tlast & (x_inc == cur_w);
    assign new_early_err = proc & s_axis.tlast & (x_inc < cur_w);
    assign frame_done    = proc & s_axis.tlast & (y_inc == cur_h);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StWaitSof;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!en || frame_done) begin
            state_d = StWaitSof;
        end else if (proc) begin
            state_d = StActive;
        end
    end

    // Counter, measurement and status logic
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        exp_w_d     = exp_w_q;
        exp_h_d     = exp_h_q;
        meas_w_d    = meas_w_q;
        meas_h_d    = meas_h_q;
        frame_cnt_d = frame_cnt_q;
        locked_d    = locked_q;
        frm_err_d   = frm_err_q;
        if (!en) begin
            x_d       = 13'd0;
            y_d       = 13'd0;
            locked_d  = 1'b0;
            frm_err_d = 1'b0;
        end else if (proc) begin
            if (s_axis.tuser) begin
                exp_w_d = eff_w;
                exp_h_d = eff_h;
            end
            if (new_sof_err) begin
                meas_h_d = y_q;
            end
            if (s_axis.tlast) begin
                meas_w_d = x_inc;
                x_d      = 13'd0;
                y_d      = y_inc;
            end else begin
                x_d = x_inc;
                y_d = base_y;
            end
            // The SOF error belongs to the aborted frame, not the restarted one
            frm_err_d = frm_err_base | new_early_err | new_late_err;
            if (frame_done) begin
                x_d         = 13'd0;
                y_d         = 13'd0;
                meas_h_d    = cur_h;
                frame_cnt_d = frame_cnt_q + FCNTW'(1);
                locked_d    = ~frm_err_d;
            end
            if (new_sof_err | new_early_err | new_late_err) begin
                locked_d = 1'b0;
            end
        end
        // A new error wins over a coincident clear
        err_sof_d   = (err_sof_q & ~clr_err) | new_sof_err;
        err_early_d = (err_early_q & ~clr_err) | new_early_err;
        err_late_d  = (err_late_q & ~clr_err) | new_late_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= 13'd0;
            y_q         <= 13'd0;
            exp_w_q     <= 13'd0;
            exp_h_q     <= 13'd0;
            meas_w_q    <= 13'd0;
            meas_h_q    <= 13'd0;
            frame_cnt_q <= '0;
            err_sof_q   <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            locked_q    <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            exp_w_q     <= exp_w_d;
            exp_h_q     <= exp_h_d;
            meas_w_q    <= meas_w_d;
            meas_h_q    <= meas_h_d;
            frame_cnt_q <= frame_cnt_d;
            err_sof_q   <= err_sof_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
            locked_q    <= locked_d;
            frm_err_q   <= frm_err_d;
        end
    end

    assign meas_w        = meas_w_q;
    assign meas_h        = meas_h_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_sof_early = err_sof_q;
    assign err_eol_early = err_early_q;
    assign err_eol_late  = err_late_q;
    assign locked        = locked_q;
endmodule

// File: tb/tb_video_stream_mon.sv
// Bench for video_stream_mon: directed scenarios plus random frames, with a
// line-level reference model of the monitor and a scoreboard on the stream.
module tb_video_stream_mon;
    localparam int unsigned DATAW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr_err = 1'b0;
    logic [12:0] exp_w = 13'd0;
    logic [12:0] exp_h = 13'd0;
    logic [12:0] meas_w, meas_h;
    logic [15:0] frame_cnt;
    logic        err_sof_early, err_eol_early, err_eol_late, locked;

    video_stream_mon_if #(.DATAW(DATAW)) s_if ();
    video_stream_mon_if #(.DATAW(DATAW)) m_if ();

    video_stream_mon #(
        .DATAW(DATAW), .EXPW(1280), .EXPH(720), .FCNTW(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .exp_w         (exp_w),
        .exp_h         (exp_h),
        .clr_err       (clr_err),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .meas_w        (meas_w),
        .meas_h        (meas_h),
        .frame_cnt     (frame_cnt),
        .err_sof_early (err_sof_early),
        .err_eol_early (err_eol_early),
        .err_eol_late  (err_eol_late),
        .locked        (locked)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    bit bp_mode = 1'b0;
    bit chk_en  = 1'b0;
    bit chk_lat = 1'b0;
    bit prev_stall = 1'b0;
    logic [DATAW+1:0] prev_beat;
    logic [DATAW+1:0] sb [$];

    // Reference model state (line granularity)
    bit m_en = 1'b0, m_active = 1'b0, m_ferr = 1'b0;
    int m_y = 0, m_w = 0, m_h = 0;
    int m_meas_w = 0, m_meas_h = 0, m_cnt = 0;
    bit m_err_sof = 1'b0, m_err_early = 1'b0, m_err_late = 1'b0, m_locked = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "/meas_w"}, meas_w, m_meas_w);
        check({tag, "/meas_h"}, meas_h, m_meas_h);
        check({tag, "/frame_cnt"}, frame_cnt, m_cnt % 65536);
        check({tag, "/err_sof_early"}, err_sof_early, m_err_sof);
        check({tag, "/err_eol_early"}, err_eol_early, m_err_early);
        check({tag, "/err_eol_late"}, err_eol_late, m_err_late);
        check({tag, "/locked"}, locked, m_locked);
    endtask

    // One line of len pixels; sof marks its first pixel, eol its last
    task automatic model_line(input int len, input bit sof, input bit eol);
        bit new_err;
        if (!m_en) return;
        if (sof) begin
            if (m_active) begin
                m_err_sof = 1'b1;
                m_meas_h  = m_y;
                m_locked  = 1'b0;
            end
            m_active = 1'b1;
            m_y      = 0;
            m_ferr   = 1'b0;
            m_w      = (exp_w == 13'd0) ? 1280 : int'(exp_w);
            m_h      = (exp_h == 13'd0) ? 720 : int'(exp_h);
        end else if (!m_active) begin
            return;
        end
        new_err = 1'b0;
        if (eol && len < m_w) begin
            m_err_early = 1'b1;
            new_err     = 1'b1;
        end
        if ((eol && len > m_w) || (!eol && len >= m_w)) begin
            m_err_late = 1'b1;
            new_err    = 1'b1;
        end
        if (new_err) begin
            m_ferr   = 1'b1;
            m_locked = 1'b0;
        end
        if (eol) begin
            m_meas_w = len;
            m_y++;
            if (m_y == m_h) begin
                m_cnt++;
                m_meas_h = m_h;
                m_locked = !m_ferr;
                m_active = 1'b0;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic send_beat(input bit u, input bit l);
        logic [DATAW-1:0] d;
        int guard;
        d = $urandom;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        guard = 0;
        while (s_if.tready !== 1'b1) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                $display("FAIL s_tready_timeout: waited %0d cycles, required under 200", guard);
                $display("%0d/%0d checks passed", n_pass, n_chk + 1);
                $fatal(1, "input stalled");
            end
        end
        @(posedge clk);
        #1;
        sb.push_back({d, u, l});
        if (chk_lat) begin
            check("latency_tvalid", m_if.tvalid, 1'b1);
            check("latency_beat", {m_if.tdata, m_if.tuser, m_if.tlast}, {d, u, l});
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_line(input int len, input bit sof, input bit eol);
        for (int p = 1; p <= len; p++) begin
            send_beat(sof && (p == 1), eol && (p == len));
        end
        model_line(len, sof, eol);
    endtask

    task automatic send_frame(input int w, input int h);
        for (int i = 0; i < h; i++) begin
            send_line(w, i == 0, 1'b1);
        end
    endtask

    task automatic pulse_clr();
        clr_err     = 1'b1;
        m_err_sof   = 1'b0;
        m_err_early = 1'b0;
        m_err_late  = 1'b0;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    task automatic en_off_on();
        en       = 1'b0;
        m_en     = 1'b0;
        m_active = 1'b0;
        m_locked = 1'b0;
        @(posedge clk);
        #1;
        en   = 1'b1;
        m_en = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        m_if.tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output side: occupancy, ordering and stall stability
    always @(negedge clk) begin
        if (chk_en) begin
            check("s_tready_vs_occupancy", s_if.tready, sb.size() < 2);
            check("m_tvalid_vs_occupancy", m_if.tvalid, sb.size() != 0);
            if (prev_stall) begin
                check("m_stable_stall", {m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast},
                      {1'b1, prev_beat});
            end
            if (m_if.tvalid && m_if.tready && sb.size() != 0) begin
                check("m_beat_order", {m_if.tdata, m_if.tuser, m_if.tlast}, sb[0]);
                void'(sb.pop_front());
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_beat  = {m_if.tdata, m_if.tuser, m_if.tlast};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int w, h, len;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;

        // Reset values
        #2;
        check("rst/s_tready", s_if.tready, 1'b0);
        check("rst/m_tvalid", m_if.tvalid, 1'b0);
        check_status("rst");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_release/s_tready_low", s_if.tready, 1'b0);
        @(posedge clk);
        #1;
        check("rst_release/s_tready_high", s_if.tready, 1'b1);
        chk_en = 1'b1;
        en     = 1'b1;
        m_en   = 1'b1;
        exp_w  = 13'd8;
        exp_h  = 13'd4;

        // Nominal: 3 clean 8x4 frames, 1-cycle latency
        chk_lat = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_frame(8, 4);
            check_status("nominal");
        end
        chk_lat = 1'b0;

        // Backpressure: 2 frames with random m_tready
        bp_mode = 1'b1;
        send_frame(8, 4);
        send_frame(8, 4);
        check_status("backpressure");
        bp_mode = 1'b0;

        // Short line: line 2 ends at pixel 6
        send_line(8, 1'b1, 1'b1);
        send_line(6, 1'b0, 1'b1);
        check_status("short_line_mid");
        send_line(8, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b1);
        check_status("short_line_end");
        pulse_clr();
        send_frame(8, 4);
        check_status("short_line_recover");

        // Missing EOL: last line runs to pixel 10
        send_line(8, 1'b1, 1'b1);
        send_line(8, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b1);
        send_line(10, 1'b0, 1'b1);
        check_status("missing_eol");
        pulse_clr();

        // Early SOF at x = 3, y = 2
        send_line(8, 1'b1, 1'b1);
        send_line(8, 1'b0, 1'b1);
        send_line(3, 1'b0, 1'b0);
        send_line(8, 1'b1, 1'b1);
        check_status("early_sof_restart");
        send_line(8, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b1);
        check_status("early_sof_next_frame");
        pulse_clr();

        // en = 0 mid-frame, beats during and before SOF are ignored
        send_line(8, 1'b1, 1'b1);
        send_line(8, 1'b0, 1'b1);
        en       = 1'b0;
        m_en     = 1'b0;
        m_active = 1'b0;
        m_locked = 1'b0;
        send_line(4, 1'b0, 1'b1);
        check_status("en_off");
        en   = 1'b1;
        m_en = 1'b1;
        send_line(5, 1'b0, 1'b1);
        check_status("pre_sof_ignored");
        send_frame(8, 4);
        check_status("en_on_frame");

        // exp_w = exp_h = 0 selects the 1280x720 defaults
        exp_w = 13'd0;
        exp_h = 13'd0;
        send_line(5, 1'b1, 1'b1);
        check_status("default_geometry");
        en_off_on();
        pulse_clr();

        // Random geometries, line lengths, data and backpressure
        for (int f = 0; f < 6; f++) begin
            bp_mode = 1'($urandom_range(0, 1));
            w = $urandom_range(3, 10);
            h = $urandom_range(2, 4);
            exp_w = 13'(w);
            exp_h = 13'(h);
            for (int i = 0; i < h; i++) begin
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, w + 3) : w;
                send_line(len, i == 0, 1'b1);
            end
            check_status("random_frame");
            if (f % 2 == 1) pulse_clr();
        end

        // Asynchronous reset mid-frame with the buffer in use
        bp_mode = 1'b1;
        exp_w   = 13'd8;
        exp_h   = 13'd4;
        send_line(8, 1'b1, 1'b1);
        send_line(4, 1'b0, 1'b0);
        chk_en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst/s_tready", s_if.tready, 1'b0);
        check("async_rst/m_tvalid", m_if.tvalid, 1'b0);
        m_active = 1'b0; m_ferr = 1'b0; m_y = 0;
        m_meas_w = 0; m_meas_h = 0; m_cnt = 0;
        m_err_sof = 1'b0; m_err_early = 1'b0; m_err_late = 1'b0; m_locked = 1'b0;
        check_status("async_rst");
        sb.delete();
        bp_mode = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst/s_tready", s_if.tready, 1'b1);
        chk_en = 1'b1;
        send_frame(8, 4);
        check_status("post_rst_frame");
        repeat (4) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/video_stream_mon.md
Name: video_stream_mon

Overview:
- Downstream consumer of the video test-pattern generator's AXI4-Stream video output (tuser = SOF, tlast = EOL).
- Passes the stream through a 2-entry register slice to the next stage (VDMA / video out).
- Monitors frame geometry against expected width/height, and reports measured size, frame count, sticky protocol errors and a lock flag for ILA/status registers.

Parameters:
- DATAW, 32, tdata width in bits.
- EXPW, 1280, reset/default expected active width (pixels).
- EXPH, 720, reset/default expected active height (lines).
- FCNTW, 16, frame counter width.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  monitor enable; 0 holds the monitor idle. The data path is unaffected.
- exp_w  in  13  expected width. Value 0 selects EXPW.
- exp_h  in  13  expected height. Value 0 selects EXPH.
- clr_err  in  1  one-cycle pulse; clears sticky errors.
- s_axis_tdata  in  DATAW  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tuser  in  1  input SOF.
- s_axis_tlast  in  1  input EOL.
- m_axis_tdata  out  DATAW  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tuser  out  1  output SOF.
- m_axis_tlast  out  1  output EOL.
- meas_w  out  13  width of the last completed line.
- meas_h  out  13  line count of the last completed or aborted frame.
- frame_cnt  out  FCNTW  completed frames; wraps.
- err_sof_early  out  1  sticky: SOF seen mid-frame.
- err_eol_early  out  1  sticky: tlast before expected width.
- err_eol_late  out  1  sticky: no tlast at expected width.
- locked  out  1  last frame matched the expected geometry with no errors.

Behaviour:
- Reset: all outputs 0, except s_axis_tready = 1 one cycle after rst deasserts (0 while rst is asserted). Buffer is empty; FSM is in WAIT_SOF.

Data path:
- 2-entry skid buffer; {tdata, tuser, tlast} carried together.
- An input beat is accepted when s_tvalid && s_tready.
- s_tready is registered and equals (occupancy < 2) after the current cycle's push/pop.
- Latency from an accepted beat to m_tvalid is 1 cycle.
- Full throughput with m_tready held high; no bubbles.
- m outputs are stable while m_tvalid && !m_tready. Order is preserved; no drops or duplicates.
- Simultaneous push and pop at occupancy 1 leaves occupancy at 1.

Monitor (observes accepted input beats only):
- Counters: x (13b, pixels in the current line) and y (13b, lines in the current frame).
- WAIT_SOF state:
  - Ignore beats without tuser.
  - A tuser beat goes to ACTIVE with x = 1, y = 0, or x = 0, y = 1 if tlast is also set.
- ACTIVE state, per beat:
  - tuser with (x != 0 or y != 0): set err_sof_early, meas_h = y, restart the frame on this beat (same as the WAIT_SOF entry), clear locked.
  - Beat without tlast where x+1 == exp_w: set err_eol_late. x continues counting, saturating at 8191.
  - tlast beat:
    - meas_w = x+1.
    - If x+1 < exp_w, set err_eol_early.
    - x = 0, y = y+1.
    - If y+1 == exp_h: meas_h = exp_h, frame_cnt += 1, go to WAIT_SOF. locked = 1 if no error was set during this frame, else 0.
- Errors are sticky until clr_err. If clr_err coincides with a new error, the new error wins (stays 1).
- Any new error clears locked in the same cycle.
- en = 0: FSM to WAIT_SOF; x, y and locked cleared. meas_w, meas_h, frame_cnt and errors are held.
- Effective exp_w / exp_h are sampled on frame start (SOF acceptance) and held for that frame.
- Async rst mid-frame: everything returns to reset values immediately. The buffer contents are discarded.

Test Plan:
- Nominal: exp_w = 8, exp_h = 4, 3 clean frames, m_tready = 1. Expect:
  - output identical to input, 1-cycle latency;
  - frame_cnt = 3, meas_w = 8, meas_h = 4;
  - locked = 1 after frame 1; no errors.
- Backpressure: random m_tready (50%) over 2 frames of 8x4. Expect:
  - s_tready drops within 1 cycle of the buffer filling;
  - no data loss or reordering (scoreboard);
  - m outputs stable while stalled.
- Short line: line 2 ends with tlast at pixel 6 (exp_w = 8). Expect:
  - err_eol_early = 1, meas_w = 6, locked = 0;
  - after clr_err plus one clean frame: err clear, locked = 1.
- Missing EOL: line has no tlast at pixel 8 and ends at pixel 10. Expect err_eol_late = 1 and meas_w = 10.
- Early SOF: tuser asserted at x = 3, y = 2. Expect err_sof_early = 1, meas_h = 2, and the next frame is counted from that beat.
- en/reset: en = 0 mid-frame, then en = 1. Expect:
  - pre-SOF beats are ignored and no error is raised;
  - rst asserted mid-frame clears all outputs asynchronously (before the next clk edge).
